// File: rtl/bit_writer_arbiter.sv
// bit_writer_arbiter: round-robin arbiter sharing one set_bit packer among NUM_REQ requesters.
// Optional BIT_ARB_SIZE_CHECK_EN drops oversize writes and raises a sticky size_error.
module bit_writer_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int MAX_BITS = 56
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [64*NUM_REQ-1:0]  req_val,
  input  logic [7*NUM_REQ-1:0]   req_size,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   enable,
  output logic [63:0]            val,
  output logic [63:0]            size_of_bit,
  output logic                   flush_bit,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic                   size_error
);
  typedef enum logic [1:0] {IDLE, GRANT, DRAIN, FLUSH} state_t;
  state_t state, state_nx;
  logic [2:0] last_owner, win_hi, win_lo, winner;
  logic any_hi, accept, fwd, oversize, cur_last;
  logic [63:0] cur_val;
  logic [6:0] cur_size;
  // Lowest valid index above the last owner wins, else lowest at or below it.
  always_comb begin
    win_hi = '0;
    win_lo = '0;
    any_hi = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && 3'(i) > last_owner) begin
        win_hi = 3'(i);
        any_hi = 1'b1;
      end
      if (req_valid[i] && 3'(i) <= last_owner) win_lo = 3'(i);
    end
    winner = any_hi ? win_hi : win_lo;
  end
  always_comb begin
    cur_val   = '0;
    cur_size  = '0;
    cur_last  = 1'b0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == 3'(i)) begin
        cur_val      = req_val[64*i +: 64];
        cur_size     = req_size[7*i +: 7];
        cur_last     = req_last[i];
        req_ready[i] = (state == GRANT);
      end
    end
  end
  assign accept = |(req_valid & req_ready);
  assign fwd    = accept && !oversize;
  assign busy   = (state != IDLE);
  always_comb begin
    state_nx = state == IDLE  ? (|req_valid ? GRANT : IDLE) :
               state == GRANT ? (accept && cur_last ? DRAIN : GRANT) :
               state == DRAIN ? FLUSH : IDLE;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_owner  <= 3'(NUM_REQ - 1);
      grant_id    <= '0;
      enable      <= 1'b0;
      val         <= '0;
      size_of_bit <= '0;
      flush_bit   <= 1'b0;
    end else begin
      state       <= state_nx;
      enable      <= fwd;
      val         <= fwd ? cur_val : '0;
      size_of_bit <= fwd ? {57'b0, cur_size} : '0;
      flush_bit   <= (state == DRAIN);
      if (state == IDLE && |req_valid) grant_id <= winner;
      if (state == FLUSH) last_owner <= grant_id;
    end
  end
`ifdef BIT_ARB_SIZE_CHECK_EN
  assign oversize = cur_size > 7'(MAX_BITS);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) size_error <= 1'b0;
    else if (accept && oversize) size_error <= 1'b1;
  end
`else
  assign oversize   = 1'b0;
  assign size_error = 1'b0;
`endif
endmodule

// File: tb/tb_bit_writer_arbiter.sv
// tb_bit_writer_arbiter: directed vector table, hand-written stall sequence and randomized
// bursts checked against a transaction-level round-robin model.
module tb_bit_writer_arbiter;
  localparam int N = 2;
  localparam int MAXB = 56;
`ifdef BIT_ARB_SIZE_CHECK_EN
  localparam int EN60 = 0, V60 = 0, S60 = 0, SE = 1;
`else
  localparam int EN60 = 1, V60 = 'hFF, S60 = 60, SE = 0;
`endif
  logic clock = 1'b0, reset_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [64*N-1:0] req_val = '0;
  logic [7*N-1:0] req_size = '0;
  logic enable, flush_bit, busy, size_error;
  logic [63:0] val, size_of_bit;
  logic [2:0] grant_id;
  int cmp = 0, err = 0;

  always #5 clock = ~clock;

  bit_writer_arbiter #(.NUM_REQ(N), .MAX_BITS(MAXB)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_val(req_val),
    .req_size(req_size), .req_last(req_last), .req_ready(req_ready), .enable(enable),
    .val(val), .size_of_bit(size_of_bit), .flush_bit(flush_bit), .grant_id(grant_id),
    .busy(busy), .size_error(size_error)
  );

  task automatic check(input string nm, input logic [159:0] a, input logic [159:0] e);
    cmp++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  typedef struct packed {
    logic rn; logic [1:0] vld, lst; logic [7:0] v0, v1; logic [6:0] s0, s1;
    logic [1:0] rdy; logic en; logic [7:0] ev; logic [6:0] es; logic fl; logic [2:0] g;
    logic bz, se;
  } row_t;
  row_t tbl[$];

  function automatic row_t r(int rn, int vld, int lst, int v0, int v1, int s0, int s1,
                             int rdy, int en, int ev, int es, int fl, int g, int bz, int se);
    r.rn = 1'(rn); r.vld = 2'(vld); r.lst = 2'(lst); r.v0 = 8'(v0); r.v1 = 8'(v1);
    r.s0 = 7'(s0); r.s1 = 7'(s1); r.rdy = 2'(rdy); r.en = 1'(en); r.ev = 8'(ev);
    r.es = 7'(es); r.fl = 1'(fl); r.g = 3'(g); r.bz = 1'(bz); r.se = 1'(se);
  endfunction

  typedef struct {logic [63:0] v; logic [6:0] s; bit l;} wr_t;
  typedef struct {bit f; logic [63:0] v; logic [6:0] s;} ev_t;
  wr_t rq[N][$];
  ev_t exp_q[$];

  initial begin
    int nb[N], pos[N], stall[N], ptr, left;
    int bl[N][$];
    bit hs[N], done;
    ev_t e;
    // rn vld lst v0 v1 s0 s1 | rdy en ev es fl g bz se
    tbl.push_back(r(1,1,0,'h05,0,3,0, 0,0,0,0,0,0,0,0));
    tbl.push_back(r(1,1,0,'h05,0,3,0, 1,0,0,0,0,0,1,0));
    tbl.push_back(r(1,1,1,'h01,0,1,0, 1,1,'h05,3,0,0,1,0));
    tbl.push_back(r(1,0,0,0,0,0,0,    0,1,'h01,1,0,0,1,0));
    tbl.push_back(r(1,0,0,0,0,0,0,    0,0,0,0,1,0,1,0));
    tbl.push_back(r(1,0,0,0,0,0,0,    0,0,0,0,0,0,0,0));
    tbl.push_back(r(0,0,0,0,0,0,0,    0,0,0,0,0,0,0,0));
    tbl.push_back(r(1,3,3,'h0A,'h0B,4,5, 0,0,0,0,0,0,0,0));
    tbl.push_back(r(1,3,3,'h0A,'h0B,4,5, 1,0,0,0,0,0,1,0));
    tbl.push_back(r(1,3,3,'h0A,'h0B,4,5, 0,1,'h0A,4,0,0,1,0));
    tbl.push_back(r(1,3,3,'h0A,'h0B,4,5, 0,0,0,0,1,0,1,0));
    tbl.push_back(r(1,3,3,'h0A,'h0B,4,5, 0,0,0,0,0,0,0,0));
    tbl.push_back(r(1,3,3,'h0A,'h0B,4,5, 2,0,0,0,0,1,1,0));
    tbl.push_back(r(0,3,3,'h0A,'h0B,4,5, 0,0,0,0,0,0,0,0));
    tbl.push_back(r(1,3,3,'h0A,'h0B,4,5, 0,0,0,0,0,0,0,0));
    tbl.push_back(r(1,3,3,'h0A,'h0B,4,5, 1,0,0,0,0,0,1,0));
    tbl.push_back(r(1,2,2,0,'h0B,0,5,    0,1,'h0A,4,0,0,1,0));
    tbl.push_back(r(1,2,2,0,'h0B,0,5,    0,0,0,0,1,0,1,0));
    tbl.push_back(r(1,2,2,0,'hFF,0,60,   0,0,0,0,0,0,0,0));
    tbl.push_back(r(1,2,2,0,'hFF,0,60,   2,0,0,0,0,1,1,0));
    tbl.push_back(r(1,0,0,0,0,0,0,       0,EN60,V60,S60,0,1,1,SE));
    tbl.push_back(r(1,0,0,0,0,0,0,       0,0,0,0,1,1,1,SE));
    tbl.push_back(r(1,1,1,0,0,0,0,       0,0,0,0,0,0,0,SE));
    tbl.push_back(r(1,1,1,0,0,0,0,       1,0,0,0,0,0,1,SE));
    tbl.push_back(r(1,0,0,0,0,0,0,       0,1,0,0,0,0,1,SE));
    tbl.push_back(r(1,0,0,0,0,0,0,       0,0,0,0,1,0,1,SE));
    tbl.push_back(r(1,0,0,0,0,0,0,       0,0,0,0,0,0,0,SE));
    repeat (2) @(posedge clock);
    #1;
    foreach (tbl[k]) begin
      reset_n = tbl[k].rn; req_valid = tbl[k].vld; req_last = tbl[k].lst;
      req_val = {56'h0, tbl[k].v1, 56'h0, tbl[k].v0};
      req_size = {tbl[k].s1, tbl[k].s0};
      #1;
      check($sformatf("vec%0d", k),
            {req_ready, enable, val, size_of_bit, flush_bit, tbl[k].bz ? grant_id : 3'd0, busy, size_error},
            {tbl[k].rdy, tbl[k].en, 56'h0, tbl[k].ev, 57'h0, tbl[k].es, tbl[k].fl, tbl[k].g, tbl[k].bz, tbl[k].se});
      @(posedge clock);
      #1;
    end
    // Owner stalls mid-burst: grant must be held and no enable issued.
    req_valid = 2'b10; req_last = 2'b00;
    req_val = {56'h0, 8'h11, 64'h0}; req_size = {7'd8, 7'd0};
    @(posedge clock); #1;
    check("stall_grant", {req_ready, grant_id, busy}, {2'b10, 3'd1, 1'b1});
    @(posedge clock); #1;
    req_valid = 2'b00;
    check("stall_first_wr", {enable, val, size_of_bit}, {1'b1, 64'h11, 64'd8});
    repeat (4) begin
      @(posedge clock); #1;
      check("stall_hold", {enable, flush_bit, req_ready, grant_id, busy}, {1'b0, 1'b0, 2'b10, 3'd1, 1'b1});
    end
    req_valid = 2'b10; req_last = 2'b10;
    req_val = {56'h0, 8'h22, 64'h0}; req_size = {7'd9, 7'd0};
    @(posedge clock); #1;
    req_valid = 2'b00; req_last = 2'b00;
    check("stall_last_wr", {enable, val, size_of_bit, req_ready}, {1'b1, 64'h22, 64'd9, 2'b00});
    @(posedge clock); #1;
    check("stall_flush", {flush_bit, enable, busy}, {1'b1, 1'b0, 1'b1});
    @(posedge clock); #1;
    check("stall_idle", {busy, flush_bit}, {1'b0, 1'b0});
    // Randomized bursts; model orders whole bursts by round-robin over requesters with work left.
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    left = 0;
    for (int i = 0; i < N; i++) begin
      nb[i] = $urandom_range(2, 4);
      left += nb[i];
      pos[i] = 0; stall[i] = 0; hs[i] = 1'b0;
      for (int b = 0; b < nb[i]; b++) begin
        int len;
        len = $urandom_range(1, 4);
        bl[i].push_back(len);
        for (int w = 0; w < len; w++)
          rq[i].push_back('{v: {$urandom, $urandom}, s: 7'($urandom_range(0, 64)), l: (w == len - 1)});
      end
    end
    ptr = N - 1;
    while (left > 0) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (ptr + k) % N;
        if (bl[j].size() > 0) begin
          for (int w = 0; w < bl[j][0]; w++) begin
            wr_t x;
            x = rq[j][pos[j] + w];
`ifdef BIT_ARB_SIZE_CHECK_EN
            if (x.s <= 7'(MAXB)) exp_q.push_back('{f: 1'b0, v: x.v, s: x.s});
`else
            exp_q.push_back('{f: 1'b0, v: x.v, s: x.s});
`endif
          end
          exp_q.push_back('{f: 1'b1, v: 64'h0, s: 7'h0});
          pos[j] += bl[j][0];
          void'(bl[j].pop_front());
          left--;
          ptr = j;
          break;
        end
      end
    end
    done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          if (!rq[i][0].l && $urandom_range(0, 2) == 0) stall[i] = $urandom_range(1, 5);
          void'(rq[i].pop_front());
        end
        if (stall[i] > 0) begin
          req_valid[i] = 1'b0;
          stall[i]--;
        end else req_valid[i] = (rq[i].size() > 0);
        if (rq[i].size() > 0) begin
          req_val[64*i +: 64] = rq[i][0].v;
          req_size[7*i +: 7] = rq[i][0].s;
          req_last[i] = rq[i][0].l;
        end
      end
      @(negedge clock);
      for (int i = 0; i < N; i++) hs[i] = req_valid[i] && req_ready[i];
      check("rand_excl", {enable & flush_bit}, 1'b0);
      if (enable || flush_bit) begin
        if (exp_q.size() == 0) check("rand_extra", {enable, flush_bit}, 2'b00);
        else begin
          e = exp_q.pop_front();
          check("rand_evt", {flush_bit, enable, val, size_of_bit}, {e.f, !e.f, e.v, 57'h0, e.s});
        end
      end
      done = (rq[0].size() == 0) && (rq[1].size() == 0) && (exp_q.size() == 0) && !busy;
      @(posedge clock); #1;
    end
    check("rand_done", done, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
